// File: rtl/axi_w_arb_pkg.sv
// Shared widths and field offsets for the AXI W burst arbiter.
// Beat layout, MSB to LSB: {data, strb, last, user}.
package axi_w_arb_pkg;

  localparam int unsigned BEAT_CNT_W = 8;

  function automatic int unsigned w_width(
    input int unsigned dw,
    input int unsigned uw
  );
    return dw + dw / 8 + 1 + uw;
  endfunction

  function automatic int unsigned last_bit(
    input int unsigned uw
  );
    return uw;
  endfunction

  function automatic int unsigned strb_lsb(
    input int unsigned uw
  );
    return uw + 1;
  endfunction

endpackage

// File: rtl/axi_w_burst_arbiter_spill.sv
// Flushable two-entry spill register (valid/ready both sides).
// Ports: i_valid/o_ready/i_data in, o_valid/i_ready/o_data out, i_flush.
module axi_w_burst_arbiter_spill #(
  parameter int unsigned W      = 8,
  parameter bit          Bypass = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  if (Bypass) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{clk_i, rst_ni, i_flush};
    assign o_valid  = i_valid;
    assign o_ready  = i_ready;
    assign o_data   = i_data;
  end else begin : g_reg
    logic         r_a_full;
    logic         r_b_full;
    logic [W-1:0] r_a_data;
    logic [W-1:0] r_b_data;
    logic         w_a_fill;
    logic         w_a_drain;
    logic         w_b_fill;
    logic         w_b_drain;

    // Slot A takes new beats; it spills into B only when the
    // slave stalls, so B always holds the older beat.
    assign w_a_fill  = i_valid && o_ready;
    assign w_a_drain = r_a_full && !r_b_full;
    assign w_b_fill  = w_a_drain && !i_ready;
    assign w_b_drain = r_b_full && i_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_a_full <= 1'b0;
        r_a_data <= '0;
      end else if (i_flush) begin
        r_a_full <= 1'b0;
      end else begin
        if (w_a_fill || w_a_drain) r_a_full <= w_a_fill;
        if (w_a_fill) r_a_data <= i_data;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_b_full <= 1'b0;
        r_b_data <= '0;
      end else if (i_flush) begin
        r_b_full <= 1'b0;
      end else begin
        if (w_b_fill || w_b_drain) r_b_full <= w_b_fill;
        if (w_b_fill) r_b_data <= r_a_data;
      end
    end

    assign o_ready = !r_a_full || !r_b_full;
    assign o_valid = r_a_full || r_b_full;
    assign o_data  = r_b_full ? r_b_data : r_a_data;
  end

endmodule

// File: rtl/axi_w_burst_arbiter.sv
// AXI W mux: grants whole bursts in the order of a select stream.
// Ports: sel_* grant order, inp_* requesters, oup_* slave, busy/cnt/err.
module axi_w_burst_arbiter
  import axi_w_arb_pkg::*;
#(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned SelDepth  = 4,
  parameter bit          Bypass    = 1'b0,
  localparam int unsigned W    = w_width(DataWidth, UserWidth),
  localparam int unsigned IdxW = $clog2(NumInp)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  sel_valid_i,
  output logic                  sel_ready_o,
  input  logic [IdxW-1:0]       sel_i,
  input  logic [NumInp-1:0]     inp_valid_i,
  output logic [NumInp-1:0]     inp_ready_o,
  input  logic [NumInp*W-1:0]   inp_data_i,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  output logic [W-1:0]          oup_data_o,
  output logic                  busy_o,
  output logic [BEAT_CNT_W-1:0] beat_cnt_o,
  output logic                  sel_err_o
);

  localparam int unsigned AddrW   = $clog2(SelDepth);
  localparam int unsigned PtrW    = AddrW + 1;
  localparam int unsigned LAST_BIT = last_bit(UserWidth);
  localparam logic [IdxW:0] NumInpL = (IdxW + 1)'(NumInp);

  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [IdxW-1:0]       r_mem [SelDepth];
  logic [BEAT_CNT_W-1:0] r_cnt;

  logic            w_empty;
  logic            w_full;
  logic            w_sel_ok;
  logic            w_push;
  logic            w_pop;
  logic            w_grant;
  logic            w_acc;
  logic            w_last;
  logic            w_spill_valid;
  logic            w_spill_ready;
  logic            w_oup_valid;
  logic [IdxW-1:0] w_head;
  logic [W-1:0]    w_beats [NumInp];
  logic [W-1:0]    w_beat;

  for (genvar k = 0; k < NumInp; k++) begin : g_inp
    assign w_beats[k] = inp_data_i[k*W +: W];
    assign inp_ready_o[k] = w_grant && (w_head == IdxW'(k));
  end

  // Pointer MSB differs only once the writer has lapped the reader.
  assign w_empty = r_wptr == r_rptr;
  assign w_full  = (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0])
                && (r_wptr[AddrW] != r_rptr[AddrW]);
  assign w_head  = r_mem[r_rptr[AddrW-1:0]];

  assign w_sel_ok    = {1'b0, sel_i} < NumInpL;
  assign sel_ready_o = !w_full && !flush_i;
  assign w_push      = sel_valid_i && sel_ready_o && w_sel_ok;
  assign sel_err_o   = sel_valid_i && sel_ready_o && !w_sel_ok;

  assign w_beat        = w_beats[w_head];
  assign w_last        = w_beat[LAST_BIT];
  assign w_spill_valid = !w_empty && inp_valid_i[w_head];
  assign w_grant       = !w_empty && w_spill_ready && !flush_i;
  assign w_acc         = w_grant && inp_valid_i[w_head];
  assign w_pop         = w_acc && w_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < SelDepth; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AddrW-1:0]] <= sel_i;
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      if (w_last) r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + BEAT_CNT_W'(1);
    end
  end

  axi_w_burst_arbiter_spill #(
    .W      (W),
    .Bypass (Bypass)
  ) u_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_flush (flush_i),
    .i_valid (w_spill_valid),
    .o_ready (w_spill_ready),
    .i_data  (w_beat),
    .o_valid (w_oup_valid),
    .i_ready (oup_ready_i),
    .o_data  (oup_data_o)
  );

  assign oup_valid_o = w_oup_valid;
  assign busy_o      = !w_empty || w_oup_valid;
  assign beat_cnt_o  = r_cnt;

endmodule
